// File: rtl/result_unloader_if.sv
// Result-buffer read port and framed output byte stream of the result unloader.
// master = unloader side, slave = buffer/consumer side.
interface result_unloader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [7:0]        dout;
   logic [1:0]        ctrl_out;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      output rd_en, rd_addr, dout, ctrl_out, dout_valid,
      input  rd_data, dout_ready
   );

   modport slave (
      input  rd_en, rd_addr, dout, ctrl_out, dout_valid,
      output rd_data, dout_ready
   );
endinterface

// File: rtl/result_unloader.sv
// Serialises the result matrix into a framed byte stream (hdr rows, hdr cols, data MSB-first, end).
// First header byte one cycle after done; each element costs 2 + ELEM_BYTES cycles; stalls hold dout while !dout_ready.
module result_unloader #(
   parameter int DATA_W     = 32,
   parameter int ELEM_BYTES = DATA_W / 8,
   parameter int MAX_ELEMS  = 16,
   parameter int ADDR_W     = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              done,
   input  logic [3:0]        res_rows,
   input  logic [3:0]        res_cols,
   result_unloader_if.master bus,
   output logic              busy,
   output logic              err
);
   localparam int BI_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;

   typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, FETCH, LOAD, BYTE, END} state_t;

   state_t            state;
   logic [3:0]        cols;
   logic [7:0]        n;
   logic [7:0]        elem_idx;
   logic [BI_W-1:0]   byte_idx;
   logic [DATA_W-1:0] shreg;

   logic              accept;
   logic [DATA_W-1:0] shreg_nxt;
   logic [7:0]        n_prod;
   logic [7:0]        elem_nxt;

   assign accept    = bus.dout_valid && bus.dout_ready;
   assign shreg_nxt = shreg << 8;
   assign n_prod    = {4'h0, res_rows} * {4'h0, res_cols};
   assign elem_nxt  = elem_idx + 8'd1;

   // Outputs are assigned on the transition into the state that presents them,
   // so every registered value is visible exactly while the FSM sits in that state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state          <= IDLE;
         cols           <= '0;
         n              <= '0;
         elem_idx       <= '0;
         byte_idx       <= '0;
         shreg          <= '0;
         busy           <= 1'b0;
         err            <= 1'b0;
         bus.rd_en      <= 1'b0;
         bus.rd_addr    <= '0;
         bus.dout       <= '0;
         bus.ctrl_out   <= '0;
         bus.dout_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (done) begin
                  cols           <= res_cols;
                  n              <= n_prod;
                  elem_idx       <= '0;
                  byte_idx       <= '0;
                  busy           <= 1'b1;
                  bus.dout       <= {4'h0, res_rows};
                  bus.ctrl_out   <= 2'd1;
                  bus.dout_valid <= 1'b1;
                  state          <= HDR_R;
               end
            end
            HDR_R: begin
               if (accept) begin
                  bus.dout <= {4'h0, cols};
                  state    <= HDR_C;
               end
            end
            HDR_C: begin
               if (accept) begin
                  if (n == 8'd0 || n > 8'(MAX_ELEMS)) begin
                     if (n > 8'(MAX_ELEMS)) err <= 1'b1;
                     bus.dout     <= 8'h00;
                     bus.ctrl_out <= 2'd2;
                     state        <= END;
                  end else begin
                     bus.dout_valid <= 1'b0;
                     bus.rd_en      <= 1'b1;
                     bus.rd_addr    <= elem_idx[ADDR_W-1:0];
                     state          <= FETCH;
                  end
               end
            end
            FETCH: begin
               bus.rd_en <= 1'b0;
               state     <= LOAD;
            end
            LOAD: begin
               // rd_data is valid now, one cycle after the FETCH strobe
               shreg          <= bus.rd_data;
               byte_idx       <= '0;
               bus.dout       <= bus.rd_data[DATA_W-1 -: 8];
               bus.ctrl_out   <= 2'd0;
               bus.dout_valid <= 1'b1;
               state          <= BYTE;
            end
            BYTE: begin
               if (accept) begin
                  shreg    <= shreg_nxt;
                  byte_idx <= byte_idx + 1'b1;
                  if (byte_idx == BI_W'(ELEM_BYTES - 1)) begin
                     elem_idx <= elem_nxt;
                     if (elem_idx == n - 8'd1) begin
                        bus.dout     <= 8'h00;
                        bus.ctrl_out <= 2'd2;
                        state        <= END;
                     end else begin
                        bus.dout_valid <= 1'b0;
                        bus.rd_en      <= 1'b1;
                        bus.rd_addr    <= elem_nxt[ADDR_W-1:0];
                        state          <= FETCH;
                     end
                  end else begin
                     bus.dout <= shreg_nxt[DATA_W-1 -: 8];
                  end
               end
            end
            END: begin
               if (accept) begin
                  busy           <= 1'b0;
                  bus.dout_valid <= 1'b0;
                  bus.dout       <= 8'h00;
                  bus.ctrl_out   <= 2'd0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: framed byte capture, stall stability, reset and error paths.
module tb_result_unloader;
   logic       CLK;
   logic       RST_N;
   logic       done;
   logic [3:0] res_rows;
   logic [3:0] res_cols;
   logic       busy;
   logic       err;

   result_unloader_if #(.DATA_W(32), .ADDR_W(4)) bus ();

   result_unloader #(.DATA_W(32), .ELEM_BYTES(4), .MAX_ELEMS(16), .ADDR_W(4)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .done     (done),
      .res_rows (res_rows),
      .res_cols (res_cols),
      .bus      (bus.master),
      .busy     (busy),
      .err      (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] mem [0:15];
   always @(posedge CLK) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ready pattern: mode 0 = always ready, mode 1 = 1,0,0,1 repeating
   int rdy_mode = 0;
   int rdy_cnt  = 0;
   initial begin
      bus.dout_ready = 1'b1;
      forever begin
         @(posedge CLK); #1;
         if (rdy_mode == 0) bus.dout_ready = 1'b1;
         else begin
            bus.dout_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
            rdy_cnt++;
         end
      end
   end

   logic [9:0]  cap_q[$];
   logic [9:0]  exp_q[$];
   logic [3:0]  addr_q[$];
   int          busy_cnt;
   int          rd_en_cnt;
   logic        prev_stall = 1'b0;
   logic [10:0] prev_word;

   always @(negedge CLK) begin
      if (!RST_N) prev_stall = 1'b0;
      else begin
         if (prev_stall)
            check("stall_hold", {21'd0, bus.dout_valid, bus.ctrl_out, bus.dout}, {21'd0, prev_word});
         if (bus.dout_valid && bus.dout_ready) cap_q.push_back({bus.ctrl_out, bus.dout});
         if (bus.rd_en) begin
            addr_q.push_back(bus.rd_addr);
            rd_en_cnt++;
         end
         if (busy) busy_cnt++;
         prev_stall = bus.dout_valid && !bus.dout_ready;
         prev_word  = {1'b1, bus.ctrl_out, bus.dout};
      end
   end

   task automatic clear_capture();
      cap_q.delete();
      addr_q.delete();
      busy_cnt  = 0;
      rd_en_cnt = 0;
   endtask

   task automatic run_frame(input logic [3:0] r, input logic [3:0] c);
      bit finished = 0;
      @(posedge CLK); #2;
      clear_capture();
      res_rows = r;
      res_cols = c;
      done     = 1'b1;
      @(posedge CLK); #2;
      done = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (!busy) begin
            finished = 1;
            break;
         end
         @(posedge CLK); #2;
      end
      check("frame_timeout", {31'd0, finished}, 32'd1);
   endtask

   task automatic compare_frame(input string tag);
      check({tag, "_len"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), {22'd0, cap_q[i]}, {22'd0, exp_q[i]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      RST_N    = 1'b0;
      done     = 1'b0;
      res_rows = 4'd0;
      res_cols = 4'd0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;

      repeat (3) @(posedge CLK);
      #1;
      check("rst_dout",  {24'd0, bus.dout}, 32'd0);
      check("rst_ctrl",  {30'd0, bus.ctrl_out}, 32'd0);
      check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_err",   {31'd0, err}, 32'd0);
      check("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
      check("rst_addr",  {28'd0, bus.rd_addr}, 32'd0);
      @(posedge CLK); #2;
      RST_N = 1'b1;

      // 1: 2x2 frame, always ready
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'hDEADBEEF;
      run_frame(4'd2, 4'd2);
      exp_q = '{10'h102, 10'h102,
                10'h000, 10'h000, 10'h000, 10'h001,
                10'h000, 10'h000, 10'h000, 10'h002,
                10'h000, 10'h000, 10'h000, 10'h003,
                10'h0DE, 10'h0AD, 10'h0BE, 10'h0EF,
                10'h200};
      compare_frame("t1");
      check("t1_addr_len", addr_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++)
         check($sformatf("t1_addr[%0d]", i), {28'd0, addr_q[i]}, i);
      check("t1_busy_cycles", busy_cnt, 32'd27);
      check("t1_err", {31'd0, err}, 32'd0);

      // 2: same frame with ready toggling 1,0,0,1
      rdy_mode = 1; rdy_cnt = 0;
      run_frame(4'd2, 4'd2);
      compare_frame("t2");
      rdy_mode = 0;

      // 3: zero rows
      run_frame(4'd0, 4'd3);
      exp_q = '{10'h100, 10'h103, 10'h200};
      compare_frame("t3");
      check("t3_rd_en_cnt", rd_en_cnt, 32'd0);
      check("t3_err", {31'd0, err}, 32'd0);

      // 4: oversize 5x4, then clean 1x1 keeps err
      run_frame(4'd5, 4'd4);
      exp_q = '{10'h105, 10'h104, 10'h200};
      compare_frame("t4");
      check("t4_err", {31'd0, err}, 32'd1);
      check("t4_rd_en_cnt", rd_en_cnt, 32'd0);
      mem[0] = 32'hA5B6C7D8;
      run_frame(4'd1, 4'd1);
      exp_q = '{10'h101, 10'h101, 10'h0A5, 10'h0B6, 10'h0C7, 10'h0D8, 10'h200};
      compare_frame("t4b");
      check("t4b_err_sticky", {31'd0, err}, 32'd1);

      // 5: done pulse during a BYTE stall is ignored
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'hDEADBEEF;
      rdy_mode = 1; rdy_cnt = 0;
      @(posedge CLK); #2;
      clear_capture();
      res_rows = 4'd2; res_cols = 4'd2; done = 1'b1;
      @(posedge CLK); #2;
      done = 1'b0;
      hit = 0;
      for (int k = 0; k < 300; k++) begin
         if (!busy) break;
         if (!hit && bus.dout_valid && !bus.dout_ready && bus.ctrl_out == 2'd0) begin
            res_rows = 4'd3; res_cols = 4'd3; done = 1'b1;
            @(posedge CLK); #2;
            done = 1'b0;
            hit  = 1;
         end else begin
            @(posedge CLK); #2;
         end
      end
      rdy_mode = 0;
      check("t5_stall_seen", {31'd0, hit}, 32'd1);
      check("t5_busy_end", {31'd0, busy}, 32'd0);
      exp_q = '{10'h102, 10'h102,
                10'h000, 10'h000, 10'h000, 10'h001,
                10'h000, 10'h000, 10'h000, 10'h002,
                10'h000, 10'h000, 10'h000, 10'h003,
                10'h0DE, 10'h0AD, 10'h0BE, 10'h0EF,
                10'h200};
      compare_frame("t5");
      mem[0] = 32'hA5B6C7D8;
      run_frame(4'd1, 4'd1);
      exp_q = '{10'h101, 10'h101, 10'h0A5, 10'h0B6, 10'h0C7, 10'h0D8, 10'h200};
      compare_frame("t5b");

      // 6: reset while presenting byte 2 of an element
      @(posedge CLK); #2;
      clear_capture();
      res_rows = 4'd1; res_cols = 4'd1; done = 1'b1;
      @(posedge CLK); #2;
      done = 1'b0;
      hit = 0;
      for (int k = 0; k < 50; k++) begin
         if (bus.dout_valid && bus.ctrl_out == 2'd0 && bus.dout == 8'hC7) begin
            hit = 1;
            break;
         end
         @(posedge CLK); #2;
      end
      check("t6_reached_byte2", {31'd0, hit}, 32'd1);
      RST_N = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("t6_rst_busy",  {31'd0, busy}, 32'd0);
      check("t6_rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
      check("t6_rst_err",   {31'd0, err}, 32'd0);
      repeat (2) @(posedge CLK);
      #2;
      RST_N = 1'b1;
      run_frame(4'd1, 4'd1);
      exp_q = '{10'h101, 10'h101, 10'h0A5, 10'h0B6, 10'h0C7, 10'h0D8, 10'h200};
      compare_frame("t6");
      check("t6_addr0", addr_q.size() > 0 ? {28'd0, addr_q[0]} : 32'hFFFF_FFFF, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
